uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Consumer side of the memory-mapped UART TX register. A CPU store to 0xF000 yields a
//  one-cycle tx_wen pulse with tx_data valid in the same cycle.
//  Buffers bytes in a small FIFO and serializes them 8N1, LSB first, on the tx pin.
//  Sits between mem (uart_tx_data/uart_tx_wen) and the board UART TX pin.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    16   byte entries; power of two, >= 2
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  rst       in   1   asynchronous, active-high reset
//  tx_data   in   8   byte to send; sampled only when tx_wen=1
//  tx_wen    in   1   push strobe, one cycle per byte
//  tx        out  1   serial line, idle high
//  full      out  1   FIFO holds FIFO_DEPTH bytes
//  busy      out  1   frame in progress OR FIFO non-empty
//  overflow  out  1   sticky: a push was dropped; cleared only by rst
// BEHAVIOUR
//  Reset (async assert, sync use after deassert): tx=1, full=0, busy=0, overflow=0,
//   FIFO empty, FSM=IDLE, bit/baud counters=0.
//  FIFO: push on tx_wen. Accepted when count<FIFO_DEPTH, or when the FSM pops in the
//   same cycle. Otherwise the byte is dropped and overflow<=1. Simultaneous push+pop
//   leaves count unchanged. Pointers wrap modulo FIFO_DEPTH. count is log2(DEPTH)+1 bits.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: tx=1. If FIFO non-empty: pop head into shift reg, baud_cnt<=0, go START.
//   START: tx=0 for CLKS_PER_BIT cycles, then go DATA with bit_idx=0.
//   DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit;
//    after bit_idx 7 completes, go STOP.
//   STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, if FIFO non-empty: pop and go
//    START (back-to-back, no idle gap). Else go IDLE.
//  baud_cnt counts 0..CLKS_PER_BIT-1; a bit ends when baud_cnt==CLKS_PER_BIT-1.
//  Latency: tx_wen at edge N (empty FIFO, IDLE) -> byte in FIFO after N -> popped at N+1
//   -> tx=0 from N+2. A frame is exactly 10*CLKS_PER_BIT cycles of tx.
//  tx is registered (no glitches). busy rises the cycle after an accepted push and falls
//   the cycle after the STOP->IDLE transition.
//  Pushes during a frame never disturb the frame in progress.
//  rst mid-frame: tx returns high immediately; FIFO contents are discarded.
// STRUCTURE
//  uart_defs.vh: FSM state encodings (IDLE=2'd0, START=1, DATA=2, STOP=3),
//   default CLKS_PER_BIT, and the UART_TX_REG/UART_RX_REG addresses shared with mem.
//  Sub-module uart_tx_fifo: sync FIFO (push, pop, din, dout, count, full, empty),
//   first-word-fall-through; dout valid whenever not empty.
//  Top: FSM, baud counter, bit counter, shift reg, overflow flag.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4; bench has a UART monitor sampling mid-bit)
//  1 Push 0x55 while idle -> tx=0 at N+2; bits 1,0,1,0,1,0,1,0; stop=1; frame is 40 cycles;
//    busy=0 afterward.
//  2 Push 0x01,0x80,0xFF,0x00 on consecutive cycles -> four frames back-to-back (160 cycles,
//    no idle gap); monitor reads the same bytes in order; overflow=0.
//  3 While frame 1 is active, push 5 bytes into an empty FIFO -> full=1 after 4 pushes;
//    5th byte is dropped and overflow=1 stays set; only 1+4 bytes are transmitted.
//  4 With full=1, push in the cycle the FSM pops -> push is accepted, count stays 4,
//    overflow stays 0.
//  5 Assert rst at the midpoint of DATA bit 3 -> tx=1 the same cycle; FIFO empty; busy=0.
//    Push 0xA5 after release -> one clean frame of 0xA5.
//  6 Idle line -> tx held at 1 for 1000 cycles with no pushes; busy=0; full=0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit path: FSM state encoding, default
// parameter values, the memory-mapped UART register addresses decoded by mem,
// and a small width helper for counters.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    // Transmit FSM states; encodings are fixed because other tooling decodes them.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
    localparam int DEFAULT_FIFO_DEPTH   = 16;
    localparam int DATA_BITS            = 8;

    // Memory-mapped register addresses shared with mem.
    localparam logic [31:0] UART_TX_REG = 32'hF000;
    localparam logic [31:0] UART_RX_REG = 32'hF004;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through byte FIFO. dout shows the head entry
// whenever empty=0. A push is taken when the FIFO is not full, or when a pop
// happens in the same cycle (the freed slot is reused); pushes that do not fit
// are ignored here and flagged by the parent.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write strobe and byte
//   pop          remove head entry (ignored when empty)
//   dout         head entry, valid while empty=0
//   count        number of stored bytes (0..DEPTH)
//   full, empty  status flags
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read after
    // it has been written, so reset would add fan-out for no behavioural gain.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Consumer side of the memory-mapped UART TX register. Bytes written by the
// CPU (one-cycle tx_wen pulse with tx_data) are queued in a FIFO and sent 8N1,
// LSB first, on the tx pin. Consecutive queued bytes go out back-to-back.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   tx_data   byte to send, sampled when tx_wen=1
//   tx_wen    push strobe, one cycle per byte
//   tx        registered serial line, idle high
//   full      FIFO holds FIFO_DEPTH bytes
//   busy      frame in progress or FIFO non-empty
//   overflow  sticky: a push was dropped; cleared only by rst
// -----------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wen,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = cnt_width(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_e     state,    state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx,  bit_nxt;
    logic [7:0]    shift,    shift_nxt;
    logic          tx_nxt;
    logic          pop;
    logic          push_ok;
    logic          baud_last;

    logic [7:0]    fifo_dout;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // A push fits if there is room, or if the FSM frees the head slot this cycle.
    assign push_ok   = tx_wen & ((fifo_count < DEPTH_CNT) | pop);
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign full      = fifo_full;
    assign busy      = (state != TX_IDLE) | ~fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            if (tx_wen && !push_ok) overflow <= 1'b1;
        end
    end

    // tx_nxt is the line level of the current state; registering it delays the
    // line by one cycle relative to the state, keeping every bit exactly
    // CLKS_PER_BIT cycles long and the pin glitch-free.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = 1'b1;
        pop       = 1'b0;

        case (state)
            TX_IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_dout;
                    state_nxt = TX_START;
                end
            end
            TX_START: begin
                tx_nxt = 1'b0;
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = TX_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                tx_nxt = shift[0];
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = TX_STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_dout;
                        state_nxt = TX_START;
                    end else begin
                        state_nxt = TX_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. A line monitor
// decodes frames by sampling tx on falling clock edges near mid-bit and records
// each byte and the cycle its start bit was seen.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_wen;
    logic       tx;
    logic       full;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       mon_abort;
    logic [7:0] mon_byte;
    int         mon_start;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_wen   (tx_wen),
        .tx       (tx),
        .full     (full),
        .busy     (busy),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- line monitor ----------------
    task automatic mon_wait(input int n);
        for (int i = 0; i < n; i++) begin
            if (mon_abort) return;
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
        end
    endtask

    initial begin
        mon_abort = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_start = cyc;
                mon_wait(1);
                if (!mon_abort) check("mon_start_bit", 32'(tx), 32'h0);
                for (int b = 0; b < 8; b++) begin
                    mon_wait(CPB);
                    mon_byte[b] = tx;
                end
                mon_wait(CPB);
                if (!mon_abort) begin
                    check("mon_stop_bit", 32'(tx), 32'h1);
                    rx_q.push_back(mon_byte);
                    start_q.push_back(mon_start);
                end
            end
        end
    end

    // ---------------- stimulus helpers (all start and end on a falling edge) ----------------
    task automatic push1(input logic [7:0] d);
        tx_data = d;
        tx_wen  = 1'b1;
        @(negedge clk);
        tx_wen  = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        start_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [7:0] exp2 [4];
        logic [7:0] exp3 [5];
        logic [7:0] exp4 [6];
        int c0;
        int lows;
        int busy_hi;

        exp2 = '{8'h01, 8'h80, 8'hFF, 8'h00};
        exp3 = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
        exp4 = '{8'h31, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

        rst     = 1'b1;
        tx_wen  = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx",       32'(tx),       32'h1);
        check("rst_busy",     32'(busy),     32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_after",  32'(tx),       32'h1);
        check("rst_full",      32'(full),     32'h0);
        check("rst_busy_after",32'(busy),     32'h0);
        check("rst_overflow",  32'(overflow), 32'h0);

        // Test 1: single byte, latency and frame length.
        clear_mon();
        c0 = cyc;
        push1(8'h55);                       // sampled at edge N, now N+0.5
        check("t1_busy_rise", 32'(busy), 32'h1);
        check("t1_tx_n0",     32'(tx),   32'h1);
        @(negedge clk);                     // N+1.5
        check("t1_tx_n1",     32'(tx),   32'h1);
        @(negedge clk);                     // N+2.5
        check("t1_tx_n2",     32'(tx),   32'h0);
        wait_until(c0 + 41);                // N+40.5, last cycle of STOP state
        check("t1_busy_stop", 32'(busy), 32'h1);
        @(negedge clk);                     // N+41.5, back in IDLE
        check("t1_busy_fall", 32'(busy), 32'h0);
        check("t1_tx_idle",   32'(tx),   32'h1);
        check("t1_rx_count",  32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) begin
            check("t1_rx_byte",  32'(rx_q[0]),    32'h55);
            check("t1_start_at", 32'(start_q[0]), 32'(c0 + 3));
        end

        // Test 2: four back-to-back frames.
        clear_mon();
        push1(8'h01);
        push1(8'h80);
        push1(8'hFF);
        push1(8'h00);
        wait_idle("t2_idle_timeout", 8 * FRAME);
        check("t2_rx_count", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t2_byte%0d", i), 32'(rx_q[i]), 32'(exp2[i]));
            end
            for (int i = 1; i < 4; i++) begin
                check($sformatf("t2_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(FRAME));
            end
        end
        check("t2_overflow", 32'(overflow), 32'h0);

        // Test 3: overflow while a frame is in flight.
        clear_mon();
        push1(8'h11);
        repeat (3) @(negedge clk);          // head popped, FIFO empty again
        push1(8'h21);
        push1(8'h22);
        push1(8'h23);
        check("t3_not_full3", 32'(full), 32'h0);
        push1(8'h24);
        check("t3_full",      32'(full),     32'h1);
        check("t3_ovf_before",32'(overflow), 32'h0);
        push1(8'h25);
        check("t3_overflow",  32'(overflow), 32'h1);
        check("t3_full_after",32'(full),     32'h1);
        wait_idle("t3_idle_timeout", 8 * FRAME);
        check("t3_rx_count",  32'(rx_q.size()), 32'd5);
        if (rx_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t3_byte%0d", i), 32'(rx_q[i]), 32'(exp3[i]));
            end
        end
        check("t3_ovf_sticky", 32'(overflow), 32'h1);

        // Test 4: push into a full FIFO in the cycle the FSM pops.
        do_reset();
        check("t4_ovf_cleared", 32'(overflow), 32'h0);
        clear_mon();
        c0 = cyc;
        push1(8'h31);                       // edge N, popped at N+1
        @(negedge clk);
        push1(8'h41);
        push1(8'h42);
        push1(8'h43);
        push1(8'h44);
        check("t4_full", 32'(full), 32'h1);
        wait_until(c0 + 41);                // N+40.5: STOP last cycle, pop at N+41
        check("t4_full_pre_pop", 32'(full), 32'h1);
        push1(8'h45);
        check("t4_full_post_pop", 32'(full),     32'h1);
        check("t4_no_overflow",   32'(overflow), 32'h0);
        wait_idle("t4_idle_timeout", 10 * FRAME);
        check("t4_rx_count", 32'(rx_q.size()), 32'd6);
        if (rx_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("t4_byte%0d", i), 32'(rx_q[i]), 32'(exp4[i]));
            end
        end
        check("t4_ovf_end", 32'(overflow), 32'h0);

        // Test 5: reset in the middle of data bit 3.
        clear_mon();
        c0 = cyc;
        push1(8'h50);                       // bit 3 is 0
        push1(8'h61);
        push1(8'h62);
        push1(8'h63);
        wait_until(c0 + 21);                // N+20.5, middle of bit 3 on the line
        check("t5_tx_bit3", 32'(tx),   32'h0);
        check("t5_busy_pre",32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_tx_rst",   32'(tx),       32'h1);
        check("t5_busy_rst", 32'(busy),     32'h0);
        check("t5_full_rst", 32'(full),     32'h0);
        check("t5_ovf_rst",  32'(overflow), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_busy_post", 32'(busy), 32'h0);
        check("t5_tx_post",   32'(tx),   32'h1);
        check("t5_rx_none",   32'(rx_q.size()), 32'd0);
        clear_mon();
        push1(8'hA5);
        wait_idle("t5_idle_timeout", 4 * FRAME);
        check("t5_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) check("t5_rx_byte", 32'(rx_q[0]), 32'hA5);

        // Test 6: idle line for 1000 cycles.
        clear_mon();
        lows    = 0;
        busy_hi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1)   lows++;
            if (busy !== 1'b0) busy_hi++;
        end
        check("t6_tx_low_cycles",  32'(lows),    32'd0);
        check("t6_busy_cycles",    32'(busy_hi), 32'd0);
        check("t6_full",           32'(full),    32'h0);
        check("t6_rx_none",        32'(rx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
